// File: rtl/gps_epoch_sched.sv
// gps_epoch_sched: run-control scheduler for the GPS P-code and C/A code
// generators, clocked by gps_clk_fast. Accepts a host start, pulses gen_load,
// then issues p_ce every RUN cycle and ca_ce once per CA_DIV cycles while
// tracking chip, 1 ms epoch and navigation data-bit boundaries. The run ends
// after nbits data bits (nbits = 0 runs until abort) or on abort.
//
// Optional build macro GPS_SCHED_PPS_ALIGN_EN: adds input pps_in. ARM then
// holds for the gen_load cycle, waits for a registered rising edge of pps_in,
// and enters RUN on the cycle after that edge is detected.
//
// All outputs are registered. Reset is synchronous and active-high.

module gps_epoch_sched #(
    parameter int CA_DIV         = 10,
    parameter int CA_CHIPS       = 1023,
    parameter int EPOCHS_PER_BIT = 20,
    parameter int CHIP_W         = 10,
    parameter int BITS_W         = 16
) (
    input  logic              gps_clk_fast,
    input  logic              gps_rst,
    input  logic              start_req,
    input  logic [BITS_W-1:0] nbits,
    input  logic              abort,
`ifdef GPS_SCHED_PPS_ALIGN_EN
    input  logic              pps_in,
`endif
    output logic              start_ack,
    output logic              busy,
    output logic              gen_load,
    output logic              p_ce,
    output logic              ca_ce,
    output logic [CHIP_W-1:0] ca_chip_idx,
    output logic              epoch_stb,
    output logic              bit_stb,
    output logic [BITS_W-1:0] bit_cnt,
    output logic              done,
    output logic              aborted
);

    localparam int DIV_W = (CA_DIV > 1) ? $clog2(CA_DIV) : 1;
    localparam int EP_W  = (EPOCHS_PER_BIT > 1) ? $clog2(EPOCHS_PER_BIT) : 1;

    // Terminal counts, sized to their counters so compares stay width-exact.
    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CA_DIV - 1);
    localparam logic [DIV_W-1:0]  DIV_PEN   = DIV_W'(CA_DIV - 2);
    localparam logic [CHIP_W-1:0] CHIP_LAST = CHIP_W'(CA_CHIPS - 1);
    localparam logic [EP_W-1:0]   EP_LAST   = EP_W'(EPOCHS_PER_BIT - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t            state;
    logic [DIV_W-1:0]  div;
    logic [EP_W-1:0]   epoch;
    logic [BITS_W-1:0] nbits_lat;

    // Modulo counters: each wraps to zero after its terminal count.
    function automatic logic [DIV_W-1:0] next_div(input logic [DIV_W-1:0] d);
        return (d == DIV_LAST) ? '0 : d + 1'b1;
    endfunction

    function automatic logic [CHIP_W-1:0] next_chip(input logic [CHIP_W-1:0] c);
        return (c == CHIP_LAST) ? '0 : c + 1'b1;
    endfunction

    function automatic logic [EP_W-1:0] next_epoch(input logic [EP_W-1:0] e);
        return (e == EP_LAST) ? '0 : e + 1'b1;
    endfunction

`ifdef GPS_SCHED_PPS_ALIGN_EN
    logic pps_q;
    logic pps_rise;

    // Registered rising-edge detect on pps_in; pps_rise is a one-cycle pulse.
    always_ff @(posedge gps_clk_fast) begin
        if (gps_rst) begin
            pps_q    <= 1'b0;
            pps_rise <= 1'b0;
        end else begin
            pps_q    <= pps_in;
            pps_rise <= pps_in & ~pps_q;
        end
    end
`endif

    // Run-control FSM with all strobes, counters and status registered here.
    always_ff @(posedge gps_clk_fast) begin
        if (gps_rst) begin
            state       <= IDLE;
            start_ack   <= 1'b0;
            busy        <= 1'b0;
            gen_load    <= 1'b0;
            p_ce        <= 1'b0;
            ca_ce       <= 1'b0;
            ca_chip_idx <= '0;
            epoch_stb   <= 1'b0;
            bit_stb     <= 1'b0;
            bit_cnt     <= '0;
            done        <= 1'b0;
            aborted     <= 1'b0;
            div         <= '0;
            epoch       <= '0;
            nbits_lat   <= '0;
        end else begin
            // Pulses default low; each state re-asserts what it needs.
            start_ack <= 1'b0;
            gen_load  <= 1'b0;
            done      <= 1'b0;
            p_ce      <= 1'b0;
            ca_ce     <= 1'b0;
            epoch_stb <= 1'b0;
            bit_stb   <= 1'b0;

            case (state)
                IDLE: begin
                    if (start_req && !abort) begin
                        state       <= ARM;
                        start_ack   <= 1'b1;
                        gen_load    <= 1'b1;
                        busy        <= 1'b1;
                        nbits_lat   <= nbits;
                        bit_cnt     <= '0;
                        ca_chip_idx <= '0;
                        epoch       <= '0;
                        div         <= '0;
                        aborted     <= 1'b0;
                    end
                end

                ARM: begin
                    if (abort) begin
                        state   <= DONE;
                        done    <= 1'b1;
                        aborted <= 1'b1;
`ifdef GPS_SCHED_PPS_ALIGN_EN
                    end else if (!gen_load && pps_rise) begin
`else
                    end else begin
`endif
                        // Divider restarts so the first RUN cycle is count 0.
                        state <= RUN;
                        p_ce  <= 1'b1;
                        div   <= '0;
                    end
                end

                RUN: begin
                    if (bit_stb && (bit_cnt == nbits_lat) && (nbits_lat != '0)) begin
                        // Final bit completed: this cycle also carried the
                        // wrapping ca_ce/epoch_stb, so chip and epoch wrap.
                        // Completion takes priority over a coincident abort.
                        state       <= DONE;
                        done        <= 1'b1;
                        ca_chip_idx <= '0;
                        epoch       <= '0;
                    end else if (abort) begin
                        // Counters freeze where they are.
                        state   <= DONE;
                        done    <= 1'b1;
                        aborted <= 1'b1;
                    end else begin
                        p_ce <= 1'b1;
                        div  <= next_div(div);
                        if (ca_ce) begin
                            ca_chip_idx <= next_chip(ca_chip_idx);
                        end
                        if (epoch_stb) begin
                            epoch <= next_epoch(epoch);
                        end
                        // Strobes for the next cycle are decoded one count
                        // early; chip/epoch cannot change on this edge then.
                        if (div == DIV_PEN) begin
                            ca_ce <= 1'b1;
                            if (ca_chip_idx == CHIP_LAST) begin
                                epoch_stb <= 1'b1;
                                if (epoch == EP_LAST) begin
                                    bit_stb <= 1'b1;
                                    bit_cnt <= bit_cnt + 1'b1;
                                end
                            end
                        end
                    end
                end

                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end

                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gps_epoch_sched.sv
// Directed, table-driven bench for gps_epoch_sched with a reduced code
// (CA_DIV=10, CA_CHIPS=7, EPOCHS_PER_BIT=2): one data bit = 140 cycles.
// Each record sets inputs, advances a number of clock edges and compares the
// packed output word. k in the notes = edges since the accepting edge.

module tb_gps_epoch_sched;

    localparam int CA_DIV   = 10;
    localparam int CA_CHIPS = 7;
    localparam int EPB      = 2;
    localparam int CHIP_W   = 10;
    localparam int BITS_W   = 16;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start_req = 1'b0;
    logic              abort = 1'b0;
    logic              pps_in = 1'b0;
    logic [BITS_W-1:0] nbits = '0;

    logic              start_ack, busy, gen_load, p_ce, ca_ce;
    logic [CHIP_W-1:0] ca_chip_idx;
    logic              epoch_stb, bit_stb, done, aborted;
    logic [BITS_W-1:0] bit_cnt;

    always #5 clk = ~clk;

    gps_epoch_sched #(
        .CA_DIV(CA_DIV), .CA_CHIPS(CA_CHIPS), .EPOCHS_PER_BIT(EPB),
        .CHIP_W(CHIP_W), .BITS_W(BITS_W)
    ) dut (
        .gps_clk_fast(clk),
        .gps_rst     (rst),
        .start_req   (start_req),
        .nbits       (nbits),
        .abort       (abort),
`ifdef GPS_SCHED_PPS_ALIGN_EN
        .pps_in      (pps_in),
`endif
        .start_ack   (start_ack),
        .busy        (busy),
        .gen_load    (gen_load),
        .p_ce        (p_ce),
        .ca_ce       (ca_ce),
        .ca_chip_idx (ca_chip_idx),
        .epoch_stb   (epoch_stb),
        .bit_stb     (bit_stb),
        .bit_cnt     (bit_cnt),
        .done        (done),
        .aborted     (aborted)
    );

    // Output word: flags {ack,busy,gl,pce,cace,ep,bs,done,ab}, idx, bit_cnt.
    typedef logic [8+CHIP_W+BITS_W:0] word_t;

    typedef struct {
        logic        r;
        logic        sreq;
        logic        abt;
        logic [15:0] nb;
        int          adv;
        word_t       exp;
    } vec_t;

    vec_t tbl[$];
    int   nvec  = 0;
    int   nfail = 0;
    int   n_ack = 0;
    int   n_done = 0;
    int   exp_ack = 0;
    int   exp_done = 0;

    function automatic word_t mk(input logic ack, input logic bsy, input logic gl,
                                 input logic pce, input logic cace, input logic ep,
                                 input logic bs, input logic dn, input logic ab,
                                 input int idx, input int bc);
        return {ack, bsy, gl, pce, cace, ep, bs, dn, ab, CHIP_W'(idx), BITS_W'(bc)};
    endfunction

    function automatic word_t obs();
        return {start_ack, busy, gen_load, p_ce, ca_ce, epoch_stb, bit_stb, done,
                aborted, ca_chip_idx, bit_cnt};
    endfunction

    task automatic add(input logic r, input logic s, input logic a,
                       input int nb, input int adv, input word_t e);
        vec_t v;
        v.r = r; v.sreq = s; v.abt = a; v.nb = 16'(nb); v.adv = adv; v.exp = e;
        tbl.push_back(v);
    endtask

    task automatic check(input string tag, input int id, input word_t got, input word_t want);
        nvec++;
        if (got !== want) begin
            nfail++;
            $display("FAIL %s %0d: got flags=%b idx=%0d bcnt=%0d, want flags=%b idx=%0d bcnt=%0d",
                     tag, id, got[8+CHIP_W+BITS_W -: 9], got[CHIP_W+BITS_W-1 -: CHIP_W],
                     got[BITS_W-1:0], want[8+CHIP_W+BITS_W -: 9],
                     want[CHIP_W+BITS_W-1 -: CHIP_W], want[BITS_W-1:0]);
        end
    endtask

    task automatic check_int(input string tag, input int got, input int want);
        nvec++;
        if (got != want) begin
            nfail++;
            $display("FAIL %s: got %0d, want %0d", tag, got, want);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Pulse counters sampled away from the active edge.
    always @(negedge clk) begin
        if (start_ack) n_ack++;
        if (done) n_done++;
    end

    initial begin
        //   r  s  a  nb adv  ack bsy gl pce cce ep bs dn ab idx bc
        add(1, 0, 0, 0, 2,   mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));  // reset state
        add(0, 1, 1, 5, 3,   mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));  // abort blocks accept
        // nbits=1 full run
        add(0, 1, 0, 1, 1,   mk(1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0));  // k=1 ack+load
        add(0, 0, 0, 1, 1,   mk(0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0));  // k=2 first p_ce
        add(0, 0, 0, 1, 8,   mk(0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0));  // k=10
        add(0, 0, 0, 1, 1,   mk(0, 1, 0, 1, 1, 0, 0, 0, 0, 0, 0));  // k=11 first ca_ce
        add(0, 0, 0, 1, 1,   mk(0, 1, 0, 1, 0, 0, 0, 0, 0, 1, 0));  // k=12 chip 1
        add(0, 0, 0, 1, 58,  mk(0, 1, 0, 1, 0, 0, 0, 0, 0, 6, 0));  // k=70
        add(0, 0, 0, 1, 1,   mk(0, 1, 0, 1, 1, 1, 0, 0, 0, 6, 0));  // k=71 epoch_stb
        add(0, 0, 0, 1, 1,   mk(0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0));  // k=72 chip wrap
        add(0, 0, 0, 1, 69,  mk(0, 1, 0, 1, 1, 1, 1, 0, 0, 6, 1));  // k=141 bit_stb
        add(0, 0, 0, 1, 1,   mk(0, 1, 0, 0, 0, 0, 0, 1, 0, 0, 1));  // k=142 done
        add(0, 0, 0, 1, 1,   mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));  // k=143 idle
        // nbits=0, abort after three bits
        add(0, 1, 0, 0, 1,   mk(1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0));  // k=1 bit_cnt cleared
        add(0, 0, 0, 0, 420, mk(0, 1, 0, 1, 1, 1, 1, 0, 0, 6, 3));  // k=421 third bit
        add(0, 0, 0, 0, 9,   mk(0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 3));  // k=430 still running
        add(0, 0, 1, 0, 1,   mk(0, 1, 0, 0, 0, 0, 0, 1, 1, 0, 3));  // k=431 aborted done
        add(0, 0, 0, 0, 1,   mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 3));  // k=432 aborted held
        // nbits=2, abort coincides with completing bit_stb
        add(0, 1, 0, 2, 1,   mk(1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0));  // k=1 aborted cleared
        add(0, 0, 0, 2, 280, mk(0, 1, 0, 1, 1, 1, 1, 0, 0, 6, 2));  // k=281 second bit
        add(0, 0, 1, 2, 1,   mk(0, 1, 0, 0, 0, 0, 0, 1, 0, 0, 2));  // k=282 completion wins
        add(0, 0, 0, 2, 1,   mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2));  // k=283
        // reset mid-run, then restart
        add(0, 1, 0, 2, 1,   mk(1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0));  // k=1
        add(0, 0, 0, 2, 49,  mk(0, 1, 0, 1, 0, 0, 0, 0, 0, 4, 0));  // k=50 chip 4
        add(1, 0, 0, 2, 1,   mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));  // all cleared
        add(0, 1, 0, 1, 1,   mk(1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0));  // acked normally
        // start_req held high through the run
        add(0, 1, 0, 1, 1,   mk(0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0));  // k=2 no re-ack
        add(0, 1, 0, 1, 139, mk(0, 1, 0, 1, 1, 1, 1, 0, 0, 6, 1));  // k=141
        add(0, 1, 0, 1, 1,   mk(0, 1, 0, 0, 0, 0, 0, 1, 0, 0, 1));  // k=142 done, no ack
        add(0, 1, 0, 1, 1,   mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));  // k=143 idle
        add(0, 1, 0, 1, 1,   mk(1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0));  // k=144 second ack
        add(0, 0, 0, 1, 1,   mk(0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0));  // k=145
        add(0, 0, 1, 1, 1,   mk(0, 1, 0, 0, 0, 0, 0, 1, 1, 0, 0));  // k=146 abort
        add(0, 0, 0, 1, 1,   mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0));  // k=147

`ifndef GPS_SCHED_PPS_ALIGN_EN
        for (int i = 0; i < tbl.size(); i++) begin
            rst       = tbl[i].r;
            start_req = tbl[i].sreq;
            abort     = tbl[i].abt;
            nbits     = tbl[i].nb;
            step(tbl[i].adv);
            check("vec", i, obs(), tbl[i].exp);
        end
        exp_ack  = 6;
        exp_done = 5;
`else
        rst = 1'b1;
        step(2);
        check("pps_reset", 0, obs(), mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        rst = 1'b0;
        // Aligned start: pps rises in k=50, first p_ce in k=52.
        start_req = 1'b1; nbits = 16'd0;
        step(1);
        check("pps_align", 1, obs(), mk(1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        start_req = 1'b0;
        step(1);
        check("pps_align", 2, obs(), mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        step(48);
        check("pps_align", 50, obs(), mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        pps_in = 1'b1;
        step(1);
        check("pps_align", 51, obs(), mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        step(1);
        check("pps_align", 52, obs(), mk(0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0));
        abort = 1'b1;
        step(1);
        check("pps_align", 53, obs(), mk(0, 1, 0, 0, 0, 0, 0, 1, 1, 0, 0));
        abort = 1'b0; pps_in = 1'b0;
        step(3);
        // Abort while waiting for pps: done, aborted, never a p_ce.
        start_req = 1'b1;
        step(1);
        check("pps_abort", 1, obs(), mk(1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        start_req = 1'b0;
        step(4);
        check("pps_abort", 5, obs(), mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        abort = 1'b1;
        step(1);
        check("pps_abort", 6, obs(), mk(0, 1, 0, 0, 0, 0, 0, 1, 1, 0, 0));
        abort = 1'b0;
        step(1);
        check("pps_abort", 7, obs(), mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
        exp_ack  = 2;
        exp_done = 2;
`endif
        step(2);
        check_int("ack_pulse_total", n_ack, exp_ack);
        check_int("done_pulse_total", n_done, exp_done);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
